// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: packet-granular round-robin merge of NUM_INPUTS AXI-Stream sources onto one CMAC TX stream.
// Ports: clk/resetn (async active-low); AXIS_IN_* packed per-input slave streams (input i at [i*DW +: DW]);
// AXIS_OUT_* merged master stream; grant = current/last granted input; busy = forwarding a packet;
// clear_counters/PKT_COUNT = per-input accepted-packet counters, present only when PKT_COUNTERS_EN is defined
// (otherwise PKT_COUNT is tied to 0 and clear_counters is ignored).
module axis_packet_arbiter #(
    parameter int DW         = 512,
    parameter int NUM_INPUTS = 4,
    parameter int IW         = $clog2(NUM_INPUTS)
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_INPUTS*DW-1:0]   AXIS_IN_TDATA,
    input  logic [NUM_INPUTS*DW/8-1:0] AXIS_IN_TKEEP,
    input  logic [NUM_INPUTS-1:0]      AXIS_IN_TLAST,
    input  logic [NUM_INPUTS-1:0]      AXIS_IN_TVALID,
    output logic [NUM_INPUTS-1:0]      AXIS_IN_TREADY,
    output logic [DW-1:0]              AXIS_OUT_TDATA,
    output logic [DW/8-1:0]            AXIS_OUT_TKEEP,
    output logic                       AXIS_OUT_TLAST,
    output logic                       AXIS_OUT_TVALID,
    input  logic                       AXIS_OUT_TREADY,
    output logic [IW-1:0]              grant,
    output logic                       busy,
    input  logic                       clear_counters,
    output logic [NUM_INPUTS*32-1:0]   PKT_COUNT
);
    typedef enum logic {IDLE, PASS} state_t;
    state_t        state, state_nxt;
    logic [IW-1:0] last, last_nxt, grant_nxt, pick, idx;
    logic          tlast_acc;
    // Scan from the farthest candidate down to last+1 so the nearest requester after last wins.
    always_comb begin
        pick = grant;
        idx  = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            idx = IW'((int'(last) + 1 + k) % NUM_INPUTS);
            if (AXIS_IN_TVALID[idx]) pick = idx;
        end
    end
    assign busy            = (state == PASS);
    assign AXIS_OUT_TDATA  = AXIS_IN_TDATA[int'(grant)*DW +: DW];
    assign AXIS_OUT_TKEEP  = AXIS_IN_TKEEP[int'(grant)*(DW/8) +: DW/8];
    assign AXIS_OUT_TLAST  = AXIS_IN_TLAST[grant];
    assign AXIS_OUT_TVALID = busy & AXIS_IN_TVALID[grant];
    assign tlast_acc       = AXIS_OUT_TVALID & AXIS_OUT_TREADY & AXIS_OUT_TLAST;
    always_comb begin
        AXIS_IN_TREADY        = '0;
        AXIS_IN_TREADY[grant] = busy & AXIS_OUT_TREADY;
    end
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        if (state == IDLE) begin
            if (|AXIS_IN_TVALID) begin
                grant_nxt = pick;
                state_nxt = PASS;
            end
        end else if (tlast_acc) begin
            last_nxt  = grant;
            state_nxt = IDLE;
        end
    end
    // last resets to the highest index so input 0 wins the first arbitration.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            grant <= '0;
            last  <= IW'(NUM_INPUTS - 1);
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
        end
    end
`ifdef PKT_COUNTERS_EN
    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_cnt
        logic [31:0] cnt;
        // clear has priority over a coincident TLAST accept.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) cnt <= '0;
            else if (clear_counters) cnt <= '0;
            else if (tlast_acc && grant == IW'(g)) cnt <= cnt + 32'd1;
        end
        assign PKT_COUNT[g*32 +: 32] = cnt;
    end
`else
    logic unused_clear;
    assign unused_clear = clear_counters;
    assign PKT_COUNT    = '0;
`endif
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb_axis_packet_arbiter: vector table, directed sequences and randomized packet traffic against a round-robin reference model.
module tb_axis_packet_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int KW = DW / 8;
`ifdef PKT_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            resetn;
    logic [N*DW-1:0] in_tdata;
    logic [N*KW-1:0] in_tkeep;
    logic [N-1:0]    in_tlast, in_tvalid, in_tready;
    logic [DW-1:0]   out_tdata;
    logic [KW-1:0]   out_tkeep;
    logic            out_tlast, out_tvalid, out_ready;
    logic [1:0]      grant;
    logic            busy, clear;
    logic [N*32-1:0] pkt_count;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] salt;
    int          npk[N];
    int          plen[N][8];

    axis_packet_arbiter #(.DW(DW), .NUM_INPUTS(N)) dut (
        .clk(clk), .resetn(resetn),
        .AXIS_IN_TDATA(in_tdata), .AXIS_IN_TKEEP(in_tkeep), .AXIS_IN_TLAST(in_tlast),
        .AXIS_IN_TVALID(in_tvalid), .AXIS_IN_TREADY(in_tready),
        .AXIS_OUT_TDATA(out_tdata), .AXIS_OUT_TKEEP(out_tkeep), .AXIS_OUT_TLAST(out_tlast),
        .AXIS_OUT_TVALID(out_tvalid), .AXIS_OUT_TREADY(out_ready),
        .grant(grant), .busy(busy), .clear_counters(clear), .PKT_COUNT(pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] bdata(input int i, input int p, input int b);
        return {8'(i), 8'(p), 16'(b) ^ salt[15:0]};
    endfunction

    function automatic logic [KW-1:0] bkeep(input int i, input int p, input int b);
        return KW'(i * 3 + p + b * 5);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        resetn    = 1'b0;
        in_tvalid = '0;
        in_tlast  = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Reference: the packet order is derived up front by rotating over the per-input packet queues;
    // per cycle the bench then knows which packet owns the output and whether it is in the bubble.
    task automatic run_engine(input int drop_pct, input int rmode);
        int   np[N], nb[N], rem[N];
        int   q[$];
        int   k, cyc, total, lst, cur, j;
        bit   in_pkt;
        logic rdy;
        logic [N-1:0] e_rdy;
        total = 0;
        for (int i = 0; i < N; i++) begin
            np[i] = 0; nb[i] = 0; rem[i] = npk[i]; total += npk[i];
        end
        lst = N - 1;
        for (int t = 0; t < total; t++) begin
            for (int d = 1; d <= N; d++) begin
                j = (lst + d) % N;
                if (rem[j] > 0) begin
                    q.push_back(j); rem[j]--; lst = j;
                    break;
                end
            end
        end
        k = 0; cyc = 0; in_pkt = 0;
        while ((k < total || in_pkt) && cyc < 2000) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (np[i] < npk[i]) begin
                    in_tdata[i*DW +: DW] = bdata(i, np[i], nb[i]);
                    in_tkeep[i*KW +: KW] = bkeep(i, np[i], nb[i]);
                    in_tlast[i]  = (nb[i] == plen[i][np[i]] - 1);
                    in_tvalid[i] = (nb[i] == 0) || ($urandom_range(99) >= 32'(drop_pct));
                end else begin
                    in_tvalid[i] = 1'b0;
                    in_tlast[i]  = 1'b0;
                end
            end
            rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : ($urandom_range(99) < 70);
            out_ready = rdy;
            #1;
            if (in_pkt) begin
                cur   = q[k];
                e_rdy = '0;
                e_rdy[cur] = rdy;
                chk("pass_busy", 64'(busy), 64'(1));
                chk("pass_grant", 64'(grant), 64'(cur));
                chk("pass_tready", 64'(in_tready), 64'(e_rdy));
                chk("pass_tvalid", 64'(out_tvalid), 64'(in_tvalid[cur]));
                if (in_tvalid[cur]) begin
                    chk("pass_tdata", 64'(out_tdata), 64'(bdata(cur, np[cur], nb[cur])));
                    chk("pass_tkeep", 64'(out_tkeep), 64'(bkeep(cur, np[cur], nb[cur])));
                    chk("pass_tlast", 64'(out_tlast), 64'(nb[cur] == plen[cur][np[cur]] - 1));
                    if (rdy) begin
                        if (nb[cur] == plen[cur][np[cur]] - 1) begin
                            np[cur]++; nb[cur] = 0; in_pkt = 0; k++;
                        end else nb[cur]++;
                    end
                end
            end else begin
                chk("idle_busy", 64'(busy), 64'(0));
                chk("idle_tvalid", 64'(out_tvalid), 64'(0));
                chk("idle_tready", 64'(in_tready), 64'(0));
                if (k < total) in_pkt = 1;
            end
            cyc++;
        end
        chk("engine_done", 64'(k), 64'(total));
        @(negedge clk);
        in_tvalid = '0;
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < N; i++)
            chk("pkt_count", 64'(pkt_count[i*32 +: 32]), CNT_EN ? 64'(npk[i]) : 64'(0));
    endtask

    task automatic set_pkts(input int a0, input int a1, input int a2, input int a3, input int len);
        npk[0] = a0; npk[1] = a1; npk[2] = a2; npk[3] = a3;
        for (int i = 0; i < N; i++)
            for (int p = 0; p < 8; p++) plen[i][p] = len;
    endtask

    typedef struct packed {
        logic [3:0] v;
        logic [3:0] l;
        logic       r;
        logic       eb;
        logic [1:0] eg;
        logic       eo;
        logic [3:0] ei;
    } vec_t;
    vec_t tbl[18];

    initial begin
        resetn = 1'b0; clear = 1'b0; out_ready = 1'b0;
        in_tdata = '0; in_tkeep = '0; in_tlast = '0; in_tvalid = '0;
        salt = $urandom;

        do_reset();
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_tvalid", 64'(out_tvalid), 64'(0));
        chk("rst_tready", 64'(in_tready), 64'(0));
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_count", 64'(pkt_count[63:0] | pkt_count[127:64]), 64'(0));

        //            valid    last     r     busy  grant  ov    in_ready
        tbl[0]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[1]  = '{4'b0110, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[2]  = '{4'b0110, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010};
        tbl[3]  = '{4'b0110, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0000};
        tbl[4]  = '{4'b0110, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010};
        tbl[5]  = '{4'b0110, 4'b0000, 1'b1, 1'b0, 2'd1, 1'b0, 4'b0000};
        tbl[6]  = '{4'b0110, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100};
        tbl[7]  = '{4'b0011, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0000};
        tbl[8]  = '{4'b1000, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0001};
        tbl[9]  = '{4'b1000, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0001};
        tbl[10] = '{4'b1000, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0001};
        tbl[11] = '{4'b1001, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001};
        tbl[12] = '{4'b1000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[13] = '{4'b1000, 4'b1000, 1'b0, 1'b1, 2'd3, 1'b1, 4'b0000};
        tbl[14] = '{4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000};
        tbl[15] = '{4'b0110, 4'b0000, 1'b1, 1'b0, 2'd3, 1'b0, 4'b0000};
        tbl[16] = '{4'b0110, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010};
        tbl[17] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 2'd1, 1'b0, 4'b0000};
        for (int i = 0; i < N; i++) in_tdata[i*DW +: DW] = 32'hD0D0_0000 | i;
        for (int r = 0; r < 18; r++) begin
            @(negedge clk);
            in_tvalid = tbl[r].v;
            in_tlast  = tbl[r].l;
            out_ready = tbl[r].r;
            #1;
            chk($sformatf("tbl%0d_busy", r), 64'(busy), 64'(tbl[r].eb));
            chk($sformatf("tbl%0d_grant", r), 64'(grant), 64'(tbl[r].eg));
            chk($sformatf("tbl%0d_tvalid", r), 64'(out_tvalid), 64'(tbl[r].eo));
            chk($sformatf("tbl%0d_tready", r), 64'(in_tready), 64'(tbl[r].ei));
            if (tbl[r].eo) begin
                chk($sformatf("tbl%0d_tdata", r), 64'(out_tdata), 64'(32'hD0D0_0000 | tbl[r].eg));
                chk($sformatf("tbl%0d_tlast", r), 64'(out_tlast), 64'(tbl[r].l[tbl[r].eg]));
            end
        end

        // Reset in the middle of a packet from input 2.
        do_reset();
        @(negedge clk);
        in_tvalid = 4'b0100; in_tlast = 4'b0000; out_ready = 1'b1;
        @(negedge clk); #1;
        chk("mid_beat1_tvalid", 64'(out_tvalid), 64'(1));
        @(negedge clk); #1;
        chk("mid_beat2_tvalid", 64'(out_tvalid), 64'(1));
        resetn = 1'b0;
        #1;
        chk("mid_rst_tvalid", 64'(out_tvalid), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_tready", 64'(in_tready), 64'(0));
        chk("mid_rst_grant", 64'(grant), 64'(0));
        @(negedge clk);
        resetn = 1'b1; in_tvalid = 4'b1111; in_tlast = 4'b1111;
        #1;
        chk("post_rst_idle", 64'(busy), 64'(0));
        @(negedge clk); #1;
        chk("post_rst_busy", 64'(busy), 64'(1));
        chk("post_rst_grant", 64'(grant), 64'(0));

        do_reset(); set_pkts(0, 0, 3, 0, 4); run_engine(0, 0);
        do_reset(); set_pkts(2, 2, 2, 2, 2); run_engine(0, 0);
        do_reset(); set_pkts(0, 1, 0, 0, 5); run_engine(0, 1);
        do_reset(); set_pkts(2, 0, 0, 2, 4); run_engine(40, 2);

        // Clear coinciding with the third TLAST accept on input 1.
        do_reset(); set_pkts(0, 2, 0, 0, 2); run_engine(0, 0);
        @(negedge clk);
        in_tvalid = 4'b0010; in_tlast = 4'b0010; out_ready = 1'b1;
        #1;
        chk("clr_idle", 64'(busy), 64'(0));
        @(negedge clk);
        clear = 1'b1;
        #1;
        chk("clr_accept_tvalid", 64'(out_tvalid), 64'(1));
        chk("clr_accept_tlast", 64'(out_tlast), 64'(1));
        @(negedge clk);
        clear = 1'b0; in_tvalid = '0;
        #1;
        chk("clr_count1", 64'(pkt_count[63:32]), 64'(0));
        chk("clr_busy", 64'(busy), 64'(0));

        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int i = 0; i < N; i++) begin
                npk[i] = int'($urandom_range(4));
                for (int p = 0; p < 8; p++) plen[i][p] = int'($urandom_range(6, 1));
            end
            run_engine(30, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
